// File: rtl/flt_cmp_if.sv
// flt_cmp_if - operand/result bundle for the binary32 less-than comparator.
//
// Signals:
//   in_valid   x1/x2 carry a compare request this cycle
//   x1, x2     binary32 operands {sign, exp[7:0], frac[22:0]}
//   out_valid  y/exception carry a registered result this cycle
//   y          1 iff x1 < x2 numerically
//   exception  1 iff either operand was NaN
//
// Modports:
//   master  requester side (drives operands, observes result)
//   slave   comparator side
interface flt_cmp_if;
  logic        in_valid;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        y;
  logic        exception;

  modport master (
    output in_valid, x1, x2,
    input  out_valid, y, exception
  );

  modport slave (
    input  in_valid, x1, x2,
    output out_valid, y, exception
  );
endinterface

// File: rtl/flt_cmp.sv
// flt_cmp - IEEE 754 binary32 less-than comparator, one-cycle latency.
//
// Evaluates y = (x1 < x2) with full IEEE ordering: +0 and -0 compare equal,
// subnormals are ordered exactly, infinities are the largest magnitudes and
// any NaN operand yields y=0 with exception=1. The compare is combinational
// from the operands; the only state is the output register.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; clears out_valid, y and exception
//   bus   flt_cmp_if.slave: in_valid/x1/x2 in, out_valid/y/exception out
module flt_cmp (
  input  logic     clk,
  input  logic     rstn,
  flt_cmp_if.slave bus
);

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // With the sign bit removed, exponent-then-fraction forms a magnitude
  // that orders correctly as a plain unsigned integer for subnormals,
  // normals and infinities alike, so no unpacking is needed.
  function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
    logic both_zero;
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (is_nan(a) || is_nan(b))
      return 1'b0;
    else if (both_zero)
      return 1'b0;
    else if (a[31] && !b[31])
      return 1'b1;
    else if (!a[31] && b[31])
      return 1'b0;
    else if (!a[31])
      return a[30:0] < b[30:0];
    else
      // Both negative: the larger magnitude is the smaller number.
      return a[30:0] > b[30:0];
  endfunction

  // Stage p0: combinational compare of the presented operands
  logic lt_p0;
  logic nan_p0;

  always_comb begin
    lt_p0  = flt_lt(bus.x1, bus.x2);
    nan_p0 = is_nan(bus.x1) || is_nan(bus.x2);
  end

  // Stage p1: output register; results hold while no request is captured
  logic vld_p1;
  logic lt_p1;
  logic nan_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      lt_p1  <= 1'b0;
      nan_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        lt_p1  <= lt_p0;
        nan_p1 <= nan_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.y         = lt_p1;
  assign bus.exception = nan_p1;

endmodule

// File: tb/tb_flt_cmp.sv
// tb_flt_cmp - self-checking bench for flt_cmp.
//
// The reference maps each non-NaN operand onto a signed integer number line
// (sign applied to the 31-bit magnitude, so both zeros land on 0) and
// compares those values; NaN is decided separately.
module tb_flt_cmp;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  flt_cmp_if bus ();

  flt_cmp dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_nan(input logic [31:0] v);
    return (v[30:23] == 8'd255) && (v[22:0] != 0);
  endfunction

  function automatic longint ref_key(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    // {exception, y}
    if (ref_nan(a) || ref_nan(b)) return 2'b10;
    return {1'b0, ref_key(a) < ref_key(b)};
  endfunction

  // One request per call; result sampled 1 time unit after the capturing edge.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [1:0] e;
    e = ref_cmp(a, b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x1 = a;
    bus.x2 = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    if (bus.y !== e[0] || bus.exception !== e[1])
      $display("  operands x1=%h x2=%h", a, b);
    check({tag, "_y"},   32'(bus.y),         32'(e[0]));
    check({tag, "_exc"}, 32'(bus.exception), 32'(e[1]));
  endtask

  function automatic logic [22:0] pick_frac();
    logic [22:0] corners [7];
    logic [22:0] r;
    int idx;
    corners[0] = 23'h000000; corners[1] = 23'h000001; corners[2] = 23'h000002;
    corners[3] = 23'h380000; corners[4] = 23'h400000; corners[5] = 23'h2FFFFF;
    corners[6] = 23'h7FFFFF;
    idx = int'($urandom_range(0, 9));
    r = 23'($urandom);
    return (idx < 7) ? corners[idx] : r;
  endfunction

  logic [31:0] sv1 [4];
  logic [31:0] sv2 [4];

  initial begin
    logic [31:0] a, b;
    logic [7:0]  eb;
    logic [1:0]  last;
    logic [22:0] mask, up, fa, fb;
    logic [7:0]  ex;
    logic        sg;

    n_checks = 0;
    n_errors = 0;

    // Reset held with a request pending: outputs cleared without any edge.
    rstn = 1'b0;
    bus.in_valid = 1'b1;
    bus.x1 = 32'h3F800000;
    bus.x2 = 32'h40000000;
    #2;
    check("rst_vld", 32'(bus.out_valid), 32'd0);
    check("rst_y",   32'(bus.y),         32'd0);
    check("rst_exc", 32'(bus.exception), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_vld", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rstn = 1'b1;

    apply("one_lt_two", 32'h3F800000, 32'h40000000);
    check("one_lt_two_y1", 32'(bus.y), 32'd1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_vld", 32'(bus.out_valid), 32'd0);
    check("async_rst_y",   32'(bus.y),         32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Sign/zero cases.
    apply("negz_posz",   32'h80000000, 32'h00000000);
    apply("neg1_minsub", 32'hBF800000, 32'h00000001);
    apply("neg2_neg1",   32'hC0000000, 32'hBF800000);
    check("neg2_neg1_y1", 32'(bus.y), 32'd1);
    apply("neg1_neg2",   32'hBF800000, 32'hC0000000);

    // NaN and infinity.
    apply("nan_one",   32'h7FC00000, 32'h3F800000);
    check("nan_one_exc1", 32'(bus.exception), 32'd1);
    apply("one_nan",   32'h3F800000, 32'h7FC00000);
    apply("snan_inf",  32'hFF800001, 32'h7F800000);
    apply("inf_max",   32'h7F800000, 32'h7F7FFFFF);
    apply("max_inf",   32'h7F7FFFFF, 32'h7F800000);
    apply("ninf_nmax", 32'hFF800000, 32'hFF7FFFFF);

    // Equality.
    apply("eq_pos", 32'h12345678, 32'h12345678);
    apply("eq_neg", 32'h92345678, 32'h92345678);

    // Sweep every exponent and sign against varied partners.
    for (int e = 0; e < 256; e++) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 4; k++) begin
          a = {s[0], e[7:0], pick_frac()};
          case (k)
            0:       eb = e[7:0];
            1:       eb = 8'($urandom);
            2:       eb = e[7:0] + 8'd1;
            default: eb = 8'hFF;
          endcase
          b = {1'($urandom), eb, pick_frac()};
          if (k[0]) apply("sweep", b, a);
          else      apply("sweep", a, b);
        end
      end
    end

    // Same exponent and sign; fractions agree above bit j.
    for (int j = 0; j < 23; j++) begin
      for (int r = 0; r < 4; r++) begin
        mask = 23'((64'd1 << j) - 64'd1);
        up   = 23'($urandom) & ~mask;
        fa   = up | (23'($urandom) & mask);
        fb   = up | (23'($urandom) & mask);
        ex   = 8'($urandom_range(0, 254));
        sg   = 1'(r);
        apply("fine", {sg, ex, fa}, {sg, ex, fb});
      end
    end

    // Streaming: four back-to-back requests, then two idle cycles.
    for (int i = 0; i < 4; i++) begin
      sv1[i] = $urandom;
      sv2[i] = $urandom;
    end
    sv1[3] = 32'hC0000000;
    sv2[3] = 32'h3F800000;
    last = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        bus.in_valid = 1'b1;
        bus.x1 = sv1[i];
        bus.x2 = sv2[i];
        last = ref_cmp(sv1[i], sv2[i]);
      end else begin
        bus.in_valid = 1'b0;
        bus.x1 = 32'h7FC00000;
        bus.x2 = 32'h00000000;
      end
      @(posedge clk);
      #1;
      check("pipe_vld", 32'(bus.out_valid), (i < 4) ? 32'd1 : 32'd0);
      check("pipe_y",   32'(bus.y),         32'(last[0]));
      check("pipe_exc", 32'(bus.exception), 32'(last[1]));
    end

    // Reset with a result in flight discards it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x1 = 32'h3F800000;
    bus.x2 = 32'h40000000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("flight_rst_vld", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("flight_post_vld", 32'(bus.out_valid), 32'd0);
    check("flight_post_y",   32'(bus.y),         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flt_cmp.md
# flt_cmp

Single-precision (IEEE 754 binary32) less-than comparator for the FPU datapath. It evaluates y = (x1 < x2) with full IEEE ordering semantics, including signed zeros, subnormals, infinities and NaN, and flags NaN operands. The block registers its result once, giving a fixed one-cycle latency, and feeds the FPU result/flag mux.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  x1/x2 are valid this cycle.
- x1  in  32  left operand, binary32 {sign, exp[7:0], frac[22:0]}.
- x2  in  32  right operand, binary32.
- out_valid  out  1  y/exception are valid this cycle.
- y  out  1  1 iff x1 < x2 numerically; 0 otherwise.
- exception  out  1  1 iff either operand is NaN.

## Operation
- Decode per operand:
  - NaN = exp==8'hFF && frac!=0. Quiet and signalling NaNs are treated identically.
  - zero = bits[30:0]==0.
  - mag = bits[30:0], compared as a 31-bit unsigned integer. This ordering is correct for normals, subnormals and infinities.
- Result selection, first match wins:
  - Either operand is NaN: y=0, exception=1.
  - Both operands are zero (any signs): y=0, because +0 == -0.
  - s1=1, s2=0: y=1.
  - s1=0, s2=1: y=0.
  - Both signs 0: y = mag1 < mag2.
  - Both signs 1: y = mag1 > mag2.
- exception=0 in every non-NaN case.
- Equal operands (bit-identical, non-NaN) give y=0.
- Subnormals are compared exactly and are never flushed to zero.
- ±Inf orders as the largest magnitude. -Inf < every finite value < +Inf.
- Compare logic is purely combinational from x1/x2. The only state is the output register.

## Timing
- Reset (rstn=0, asynchronous) forces out_valid=0, y=0, exception=0 immediately, independent of clk.
- Release of reset is synchronised to clk by the integrating level. The first capture occurs on the first rising edge with rstn=1.
- Capture on each rising edge:
  - out_valid <= in_valid.
  - When in_valid=1: y and exception <= combinational results.
  - When in_valid=0: y and exception hold their previous values.
- Latency: exactly 1 cycle from in_valid to out_valid.
- Throughput: 1 compare per cycle. No backpressure and no stall input.
- Back-to-back in_valid pulses produce back-to-back out_valid, in order.
- Reset asserted mid-stream discards the in-flight result: out_valid=0 until a new in_valid is captured.
- Inputs must be stable for setup/hold around the capturing edge. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rstn=0 with in_valid=1 → out_valid=0, y=0, exception=0 asynchronously. Deassert, drive x1=32'h3F800000 (1.0), x2=32'h40000000 (2.0) → next cycle out_valid=1, y=1, exception=0.
- Sign and zero cases, one per cycle:
  - x1=32'h80000000 (-0), x2=32'h00000000 (+0) → y=0.
  - x1=32'hBF800000 (-1.0), x2=32'h00000001 (min subnormal) → y=1.
  - x1=32'hC0000000 (-2.0), x2=32'hBF800000 (-1.0) → y=1.
  - Swap the -2.0/-1.0 operands → y=0.
- NaN handling: x1=32'h7FC00000 with x2=32'h3F800000 → y=0, exception=1. Swap the operands → y=0, exception=1. x1=32'h7F800000 (+Inf), x2=32'h7F7FFFFF (max finite) → y=0, exception=0. Swap → y=1.
- Exhaustive sweep (must match a software reference for both y and exception):
  - All exponents 0..255 × both signs for each operand.
  - Fraction corners per operand: 0, 1, 2, 23'h380000, 23'h400000, 23'h2FFFFF, 23'h7FFFFF, plus random fractions.
  - Same-exponent pairs whose fractions differ only in bit positions below j, for j = 0..22, to exercise fine-grain magnitude compare.
- Pipelining: stream 4 consecutive in_valid vectors, then in_valid=0 for 2 cycles → out_valid follows the in_valid pattern delayed by one cycle. y holds the last result while out_valid=0.
- Equality: x1=x2=32'h12345678 → y=0. x1=x2=32'h92345678 → y=0.
